// File: rtl/pcie_tx_tlp_arb_if.sv
// Bundles the per-channel user streams and the core transmit AXI-stream.
// master: arbiter view; slave: the environment (sources and core).
interface pcie_tx_tlp_arb_if #(
    parameter int PCIE_DATA_WIDTH = 64,
    parameter int PCIE_KEEP_WIDTH = PCIE_DATA_WIDTH/8,
    parameter int NUM_CH          = 4
);
    logic [NUM_CH*PCIE_DATA_WIDTH-1:0] ch_tdata;
    logic [NUM_CH*PCIE_KEEP_WIDTH-1:0] ch_tkeep;
    logic [NUM_CH*4-1:0]               ch_tuser;
    logic [NUM_CH-1:0]                 ch_tlast;
    logic [NUM_CH-1:0]                 ch_tvalid;
    logic [NUM_CH-1:0]                 ch_tready;

    logic [PCIE_DATA_WIDTH-1:0]        s_axis_tx_tdata;
    logic [PCIE_KEEP_WIDTH-1:0]        s_axis_tx_tkeep;
    logic [3:0]                        s_axis_tx_tuser;
    logic                              s_axis_tx_tlast;
    logic                              s_axis_tx_tvalid;
    logic                              s_axis_tx_tready;

    modport master (
        input  ch_tdata, ch_tkeep, ch_tuser, ch_tlast, ch_tvalid, s_axis_tx_tready,
        output ch_tready, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
               s_axis_tx_tlast, s_axis_tx_tvalid
    );

    modport slave (
        output ch_tdata, ch_tkeep, ch_tuser, ch_tlast, ch_tvalid, s_axis_tx_tready,
        input  ch_tready, s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
               s_axis_tx_tlast, s_axis_tx_tvalid
    );
endinterface

// File: rtl/pcie_tx_tlp_arb.sv
// Round-robin whole-packet TLP arbiter in front of the PCIe core transmit stream,
// with config-slot windows between packets, buffer-credit gating and link-loss flush.
module pcie_tx_tlp_arb #(
    parameter int PCIE_DATA_WIDTH = 64,
    parameter int PCIE_KEEP_WIDTH = PCIE_DATA_WIDTH/8,
    parameter int NUM_CH          = 4,
    parameter int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int BUF_AV_MIN      = 2
) (
    input  logic                 pcie_clk_in,
    input  logic                 pcie_reset_out,
    input  logic                 pcie_link_up,
    pcie_tx_tlp_arb_if.master    bus,
    input  logic [5:0]           tx_buf_av,
    input  logic                 tx_cfg_req,
    output logic                 tx_cfg_gnt,
    output logic [CH_W-1:0]      grant_ch,
    output logic                 busy,
    output logic [15:0]          pkt_cnt,
    output logic [15:0]          drop_cnt
);
    typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

    localparam int unsigned    NCH    = NUM_CH;
    localparam logic [5:0]     AV_MIN = 6'(BUF_AV_MIN);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t                    state;
    logic [CH_W-1:0]           last_grant;
    logic [CH_W-1:0]           next_ch;
    logic [CH_W-1:0]           cand;
    logic                      found;
    logic                      grant_ok;

    logic [PCIE_DATA_WIDTH-1:0] sel_tdata;
    logic [PCIE_KEEP_WIDTH-1:0] sel_tkeep;
    logic [3:0]                 sel_tuser;
    logic                       sel_tlast;
    logic                       sel_tvalid;
    logic                       out_tvalid;
    logic [NUM_CH-1:0]          tready_vec;
    logic                       beat;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        found   = 1'b0;
        next_ch = last_grant;
        cand    = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = CH_W'((32'(last_grant) + i) % NCH);
            if (!found && bus.ch_tvalid[cand]) begin
                found   = 1'b1;
                next_ch = cand;
            end
        end
    end

    assign grant_ok = found && pcie_link_up && (tx_buf_av >= AV_MIN) && !tx_cfg_req;

    assign sel_tdata  = bus.ch_tdata[grant_ch*PCIE_DATA_WIDTH +: PCIE_DATA_WIDTH];
    assign sel_tkeep  = bus.ch_tkeep[grant_ch*PCIE_KEEP_WIDTH +: PCIE_KEEP_WIDTH];
    assign sel_tuser  = bus.ch_tuser[grant_ch*4 +: 4];
    assign sel_tlast  = bus.ch_tlast[grant_ch];
    assign sel_tvalid = bus.ch_tvalid[grant_ch];

    always_comb begin
        out_tvalid = 1'b0;
        tready_vec = '0;
        case (state)
            XFER: begin
                out_tvalid           = sel_tvalid;
                tready_vec[grant_ch] = bus.s_axis_tx_tready;
            end
            // Drain the granted source without presenting anything to the core.
            FLUSH:   tready_vec[grant_ch] = 1'b1;
            default: ;
        endcase
    end

    assign beat = out_tvalid && bus.s_axis_tx_tready;

    assign bus.s_axis_tx_tdata  = sel_tdata;
    assign bus.s_axis_tx_tkeep  = sel_tkeep;
    assign bus.s_axis_tx_tuser  = sel_tuser;
    assign bus.s_axis_tx_tlast  = sel_tlast;
    assign bus.s_axis_tx_tvalid = out_tvalid;
    assign bus.ch_tready        = tready_vec;

    always_ff @(posedge pcie_clk_in) begin
        if (pcie_reset_out) begin
            state      <= IDLE;
            tx_cfg_gnt <= 1'b0;
            busy       <= 1'b0;
            grant_ch   <= '0;
            last_grant <= LAST_CH;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_cfg_gnt <= tx_cfg_req;
                    if (grant_ok) begin
                        grant_ch <= next_ch;
                        busy     <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    tx_cfg_gnt <= 1'b0;
                    if (beat && sel_tlast) begin
                        last_grant <= grant_ch;
                        pkt_cnt    <= pkt_cnt + 16'd1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (!pcie_link_up && !beat) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    tx_cfg_gnt <= 1'b0;
                    if (sel_tvalid && sel_tlast) begin
                        last_grant <= grant_ch;
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_tx_tlp_arb.sv
// Directed bench for pcie_tx_tlp_arb: round-robin order, cfg windows, credit gating,
// link-loss flush, tready backpressure and mid-packet reset.
module tb_pcie_tx_tlp_arb;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int NC = 4;

    int checks   = 0;
    int failures = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_up;
    logic [5:0]  buf_av;
    logic        cfg_req;
    logic        cfg_gnt;
    logic [1:0]  grant_ch;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    int pkts_left[NC];
    int beat_idx[NC];
    int pkt_no[NC];
    int pkt_len[NC];
    logic [63:0] q[$];

    always #5 clk = ~clk;

    pcie_tx_tlp_arb_if #(.PCIE_DATA_WIDTH(DW), .PCIE_KEEP_WIDTH(KW), .NUM_CH(NC)) bus ();

    pcie_tx_tlp_arb #(
        .PCIE_DATA_WIDTH(DW), .PCIE_KEEP_WIDTH(KW), .NUM_CH(NC), .CH_W(2), .BUF_AV_MIN(2)
    ) dut (
        .pcie_clk_in    (clk),
        .pcie_reset_out (rst),
        .pcie_link_up   (link_up),
        .bus            (bus),
        .tx_buf_av      (buf_av),
        .tx_cfg_req     (cfg_req),
        .tx_cfg_gnt     (cfg_gnt),
        .grant_ch       (grant_ch),
        .busy           (busy),
        .pkt_cnt        (pkt_cnt),
        .drop_cnt       (drop_cnt)
    );

    function automatic logic [63:0] beat_data(input int ch, input int pkt, input int b);
        return {8'hA5, 32'h0, 8'(ch), 8'(pkt), 8'(b)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int ch = 0; ch < NC; ch++) begin
            bus.ch_tvalid[ch]             = pkts_left[ch] > 0;
            bus.ch_tlast[ch]              = beat_idx[ch] == pkt_len[ch] - 1;
            bus.ch_tdata[ch*DW +: DW]     = beat_data(ch, pkt_no[ch], beat_idx[ch]);
            bus.ch_tkeep[ch*KW +: KW]     = '1;
            bus.ch_tuser[ch*4 +: 4]       = 4'(ch);
        end
    endtask

    task automatic load(input int ch, input int n, input int len);
        pkts_left[ch] = n;
        pkt_len[ch]   = len;
        beat_idx[ch]  = 0;
    endtask

    // Source/sink model: record handshakes before the edge, advance sources after it.
    task automatic tick();
        logic [NC-1:0] acc;
        @(negedge clk);
        acc = bus.ch_tvalid & bus.ch_tready;
        if (bus.s_axis_tx_tvalid && bus.s_axis_tx_tready) q.push_back(bus.s_axis_tx_tdata);
        @(posedge clk);
        #1;
        for (int ch = 0; ch < NC; ch++) begin
            if (acc[ch]) begin
                if (beat_idx[ch] == pkt_len[ch] - 1) begin
                    pkts_left[ch]--;
                    pkt_no[ch]++;
                    beat_idx[ch] = 0;
                end else begin
                    beat_idx[ch]++;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gnt"},    64'(cfg_gnt), 64'd0);
        check({tag, "_busy"},   64'(busy), 64'd0);
        check({tag, "_grant"},  64'(grant_ch), 64'd0);
        check({tag, "_pkt"},    64'(pkt_cnt), 64'd0);
        check({tag, "_drop"},   64'(drop_cnt), 64'd0);
        check({tag, "_tvalid"}, 64'(bus.s_axis_tx_tvalid), 64'd0);
        check({tag, "_tready"}, 64'(bus.ch_tready), 64'd0);
    endtask

    initial begin
        rst = 1'b1; link_up = 1'b1; buf_av = 6'd8; cfg_req = 1'b0;
        bus.s_axis_tx_tready = 1'b1;
        for (int ch = 0; ch < NC; ch++) begin
            pkts_left[ch] = 0; beat_idx[ch] = 0; pkt_no[ch] = 0; pkt_len[ch] = 1;
        end
        drive();
        tick(); tick();
        rst = 1'b0;
        #1;
        check_reset_state("rst0");

        // 1: four 3-beat packets, round-robin 0..3, one IDLE cycle between packets
        for (int ch = 0; ch < NC; ch++) load(ch, 1, 3);
        drive();
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e % 4 == 1) begin
                check($sformatf("t1_grant_e%0d", e), 64'(grant_ch), 64'(e / 4));
                check($sformatf("t1_busy_e%0d", e), 64'(busy), 64'd1);
            end
            check($sformatf("t1_pkt_e%0d", e), 64'(pkt_cnt), 64'(e / 4));
        end
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_nbeats", 64'(q.size()), 64'd12);
        for (int i = 0; i < 12 && i < q.size(); i++)
            check($sformatf("t1_data%0d", i), q[i], beat_data(i / 3, 0, i % 3));
        q.delete();

        // 2: ch2 alone twice, then ch1+ch3 together -> ch3 first
        load(2, 2, 2);
        drive();
        tick(); check("t2_grant_a", 64'(grant_ch), 64'd2);
        tick(); tick();
        tick(); check("t2_grant_b", 64'(grant_ch), 64'd2);
        check("t2_busy_b", 64'(busy), 64'd1);
        tick(); tick();
        check("t2_pkt_a", 64'(pkt_cnt), 64'd6);
        load(1, 1, 1); load(3, 1, 1);
        drive();
        tick(); check("t2_grant_c", 64'(grant_ch), 64'd3);
        tick();
        tick(); check("t2_grant_d", 64'(grant_ch), 64'd1);
        tick();
        check("t2_pkt_b", 64'(pkt_cnt), 64'd8);
        check("t2_nbeats", 64'(q.size()), 64'd6);
        if (q.size() == 6) begin
            check("t2_data1", q[1], beat_data(2, 1, 1));
            check("t2_data2", q[2], beat_data(2, 2, 0));
            check("t2_data4", q[4], beat_data(3, 1, 0));
            check("t2_data5", q[5], beat_data(1, 1, 0));
        end
        q.delete();

        // 3: cfg request holds off ch0, grant follows the cycle after release
        cfg_req = 1'b1;
        load(0, 1, 1);
        drive();
        tick();
        check("t3_gnt_a",    64'(cfg_gnt), 64'd1);
        check("t3_busy_a",   64'(busy), 64'd0);
        check("t3_tready_a", 64'(bus.ch_tready), 64'd0);
        check("t3_tvalid_a", 64'(bus.s_axis_tx_tvalid), 64'd0);
        tick();
        check("t3_gnt_b",  64'(cfg_gnt), 64'd1);
        check("t3_busy_b", 64'(busy), 64'd0);
        cfg_req = 1'b0;
        tick();
        check("t3_gnt_c",    64'(cfg_gnt), 64'd0);
        check("t3_busy_c",   64'(busy), 64'd1);
        check("t3_grant_c",  64'(grant_ch), 64'd0);
        check("t3_tready_c", 64'(bus.ch_tready), 64'd1);
        tick();
        check("t3_pkt", 64'(pkt_cnt), 64'd9);

        // 4: insufficient buffer credit blocks ch1
        buf_av = 6'd1;
        load(1, 1, 1);
        drive();
        tick(); tick();
        check("t4_busy_a",   64'(busy), 64'd0);
        check("t4_tready_a", 64'(bus.ch_tready), 64'd0);
        buf_av = 6'd2;
        tick();
        check("t4_busy_b",  64'(busy), 64'd1);
        check("t4_grant_b", 64'(grant_ch), 64'd1);
        tick();
        check("t4_pkt", 64'(pkt_cnt), 64'd10);
        buf_av = 6'd8;
        q.delete();

        // 5: link loss after two beats of a 5-beat ch0 packet
        load(0, 1, 5);
        drive();
        tick(); check("t5_grant", 64'(grant_ch), 64'd0);
        tick(); tick();
        link_up = 1'b0;
        bus.s_axis_tx_tready = 1'b0;
        tick();
        check("t5_busy_f",   64'(busy), 64'd1);
        check("t5_tvalid_f", 64'(bus.s_axis_tx_tvalid), 64'd0);
        check("t5_tready_f", 64'(bus.ch_tready), 64'd1);
        bus.s_axis_tx_tready = 1'b1;
        tick(); tick();
        check("t5_busy_g",   64'(busy), 64'd1);
        check("t5_tvalid_g", 64'(bus.s_axis_tx_tvalid), 64'd0);
        tick();
        check("t5_busy_end", 64'(busy), 64'd0);
        check("t5_drop",     64'(drop_cnt), 64'd1);
        check("t5_pkt",      64'(pkt_cnt), 64'd10);
        check("t5_nbeats",   64'(q.size()), 64'd2);
        if (q.size() == 2) begin
            check("t5_data0", q[0], beat_data(0, 2, 0));
            check("t5_data1", q[1], beat_data(0, 2, 1));
        end
        link_up = 1'b1;
        q.delete();

        // 6a: tready toggling during a 4-beat ch1 packet
        load(1, 1, 4);
        drive();
        tick(); check("t6_grant_a", 64'(grant_ch), 64'd1);
        for (int k = 0; k < 7; k++) begin
            bus.s_axis_tx_tready = (k % 2 == 0);
            #1;
            check($sformatf("t6_tready_k%0d", k), 64'(bus.ch_tready), (k % 2 == 0) ? 64'd2 : 64'd0);
            check($sformatf("t6_tvalid_k%0d", k), 64'(bus.s_axis_tx_tvalid), 64'd1);
            tick();
        end
        check("t6_busy_a", 64'(busy), 64'd0);
        check("t6_pkt_a",  64'(pkt_cnt), 64'd11);
        check("t6_nbeats", 64'(q.size()), 64'd4);
        for (int j = 0; j < 4 && j < q.size(); j++)
            check($sformatf("t6_data%0d", j), q[j], beat_data(1, 3, j));
        bus.s_axis_tx_tready = 1'b1;

        // 6b: reset in the middle of a ch2 packet, then pointer restarts at ch0
        load(2, 1, 4);
        drive();
        tick(); check("t6_grant_b", 64'(grant_ch), 64'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset_state("t6_rst");
        load(0, 1, 1);
        drive();
        tick();
        check("t6_grant_c", 64'(grant_ch), 64'd0);
        check("t6_busy_c",  64'(busy), 64'd1);
        tick();
        check("t6_pkt_c", 64'(pkt_cnt), 64'd1);
        tick();
        check("t6_grant_d", 64'(grant_ch), 64'd2);
        tick(); tick();
        check("t6_pkt_d",  64'(pkt_cnt), 64'd2);
        check("t6_busy_d", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pcie_tx_tlp_arb.md
Name: pcie_tx_tlp_arb

Overview:
- Parametrised N-channel TLP arbiter feeding the PCIe core transmit AXI-stream (s_axis_tx_*).
- Grants whole packets to user channels in round-robin order.
- Opens windows for core-originated config traffic (tx_cfg_req/tx_cfg_gnt) only between packets.
- Gates new packets on transmit buffer credit (tx_buf_av); flushes in-flight packets on link loss.

Parameters:
- PCIE_DATA_WIDTH, 64: tdata width; legal values 64, 128, 256.
- PCIE_KEEP_WIDTH, PCIE_DATA_WIDTH/8: tkeep width, one bit per byte.
- NUM_CH, 4: number of user source channels, 1..8.
- CH_W, max(1,$clog2(NUM_CH)): width of channel index.
- BUF_AV_MIN, 2: minimum tx_buf_av required to start a new packet.

Ports:
- pcie_clk_in  in  1  sole clock.
- pcie_reset_out  in  1  synchronous, active-high reset.
- pcie_link_up  in  1  link status from core.
- ch_tdata  in  NUM_CH*PCIE_DATA_WIDTH  per-channel data; channel i at slice [i*W +: W].
- ch_tkeep  in  NUM_CH*PCIE_KEEP_WIDTH  per-channel byte enables.
- ch_tuser  in  NUM_CH*4  per-channel tuser, same encoding as s_axis_tx_tuser.
- ch_tlast  in  NUM_CH  per-channel end of packet.
- ch_tvalid  in  NUM_CH  per-channel valid.
- ch_tready  out  NUM_CH  per-channel ready.
- s_axis_tx_tdata  out  PCIE_DATA_WIDTH  to core.
- s_axis_tx_tkeep  out  PCIE_KEEP_WIDTH  to core.
- s_axis_tx_tuser  out  4  to core.
- s_axis_tx_tlast  out  1  to core.
- s_axis_tx_tvalid  out  1  to core.
- s_axis_tx_tready  in  1  from core.
- tx_buf_av  in  6  available transmit buffers.
- tx_cfg_req  in  1  core requests transmit slot.
- tx_cfg_gnt  out  1  slot granted to core.
- grant_ch  out  CH_W  channel currently or last granted.
- busy  out  1  packet in flight (XFER or FLUSH).
- pkt_cnt  out  16  packets forwarded; wraps at 0xFFFF -> 0.
- drop_cnt  out  16  packets flushed; saturates at 0xFFFF.

Behaviour:
- Reset values:
  - Registered outputs: tx_cfg_gnt=0, busy=0, grant_ch=0, pkt_cnt=0, drop_cnt=0.
  - Internal last-grant pointer = NUM_CH-1, so the first grant after reset goes to ch0.
  - Combinational outputs with state=IDLE: s_axis_tx_tvalid=0, ch_tready=0.
- State machine: IDLE, XFER, FLUSH.
- IDLE:
  - Datapath: s_axis_tx_tvalid=0, ch_tready=0.
  - tx_cfg_gnt is registered; it equals tx_cfg_req sampled in IDLE, so it is 1 cycle late.
  - While tx_cfg_req=1, no packet grant is issued; config traffic has priority.
  - Otherwise, a grant is issued when all of these hold: any ch_tvalid=1, pcie_link_up=1, tx_buf_av>=BUF_AV_MIN.
  - Grant target: first requesting channel searching from last-grant+1, modulo NUM_CH.
  - On a grant: register grant_ch, go to XFER next cycle, set busy=1.
  - Grant latency: 1 cycle from request visible to first beat presented.
- XFER:
  - tx_cfg_gnt=0.
  - Combinational mux:
    - s_axis_tx_{tdata,tkeep,tuser,tlast,tvalid} = selected channel's inputs.
    - ch_tready[grant_ch] = s_axis_tx_tready; all other ch_tready=0.
  - A beat transfers when tvalid && tready.
  - Beat with tlast: go to IDLE, last-grant=grant_ch, pkt_cnt+1, busy=0.
  - Packets are atomic: no re-arbitration mid-packet.
  - tx_cfg_req and tx_buf_av are ignored mid-packet.
  - Zero-bubble packet chaining is not required: one IDLE cycle occurs between packets.
- FLUSH:
  - Entry: pcie_link_up sampled low in XFER, with no beat completing that cycle.
  - s_axis_tx_tvalid=0; ch_tready[grant_ch]=1.
  - Source beats are discarded until a tlast beat is accepted.
  - Then: IDLE, last-grant=grant_ch, drop_cnt+1 (saturating), busy=0.
  - A tlast beat completing in the same cycle the link drops counts as sent, not dropped.
- Simultaneous events:
  - tx_cfg_req rising in the same cycle as a grant decision: the cfg request wins and no grant is issued.
  - Grant and tx_cfg_gnt are never asserted in the same cycle.
- pcie_reset_out mid-packet: everything returns to reset values next cycle; any partial packet on the core interface is abandoned.
- NUM_CH=1: arbitration degenerates to a single channel; grant_ch stays 0.

Test Plan:
1. Reset, then ch0..ch3 each hold a 3-beat packet, tready=1, tx_buf_av=8 -> order 0,1,2,3; each packet 3 beats + 1 IDLE; pkt_cnt=4.
2. Only ch2 requests repeatedly (2 packets) -> grant_ch=2 both times; then ch1 and ch3 request together -> ch3 granted first (pointer after 2).
3. tx_cfg_req=1 while ch0 valid in IDLE -> tx_cfg_gnt=1 one cycle later, no ch_tready; drop req -> gnt=0, ch0 granted next cycle.
4. tx_buf_av=1 (BUF_AV_MIN=2) with ch1 valid -> no grant; raise to 2 -> grant 1 cycle later.
5. Link drops after beat 2 of a 5-beat ch0 packet -> beats 3..5 consumed with s_axis_tx_tvalid=0; drop_cnt=1, pkt_cnt unchanged.
6. s_axis_tx_tready toggling 1/0 during a 4-beat packet, plus reset asserted mid-packet -> data matches beat-for-beat; after reset, all outputs at reset values and next grant goes to ch0.
